// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command engine.
// Holds the opcode set, argument/reply length helpers, the NACK byte and
// the bit layout of the status readback byte.
package serial_cmd_pkg;

    typedef enum logic [7:0] {
        CMD_VERSION         = 8'd0,
        CMD_SET_OUTPUTS     = 8'd1,
        CMD_SET_PLL         = 8'd2,
        CMD_SET_PASSTHROUGH = 8'd3,
        CMD_SEND_HISTOGRAM  = 8'd4,
        CMD_SET_PMT_VETO    = 8'd5,
        CMD_RESET_PLL       = 8'd6,
        CMD_SET_TEST_INPUTS = 8'd7,
        CMD_GET_STATUS      = 8'd8
    } cmd_t;

    localparam logic [7:0] NACK_BYTE = 8'hEE;

    // Status byte 1 layout, LSB first
    localparam int unsigned ST_DRIVERS_EN  = 0;
    localparam int unsigned ST_VETO_LSB    = 1;
    localparam int unsigned ST_PASSTHROUGH = 4;
    localparam int unsigned ST_INT_PULSE   = 5;
    localparam int unsigned ST_EXT_PULSE   = 6;
    localparam int unsigned ST_PLL_CLK_SRC = 7;

    // Argument bytes following the opcode; unknown opcodes take none
    function automatic int unsigned arg_count(cmd_t cmd, int unsigned npll);
        case (cmd)
            CMD_SET_OUTPUTS, CMD_SET_PASSTHROUGH,
            CMD_SET_PMT_VETO, CMD_SET_TEST_INPUTS: arg_count = 1;
            CMD_SET_PLL:                           arg_count = npll + 1;
            default:                               arg_count = 0;
        endcase
    endfunction

    // Reply bytes; unknown opcodes answer with a single NACK
    function automatic int unsigned reply_len(cmd_t cmd, int unsigned nbins,
                                              int unsigned nextra, int unsigned binw);
        case (cmd)
            CMD_VERSION:        reply_len = 1;
            CMD_SEND_HISTOGRAM: reply_len = (nbins + nextra) * binw / 8 + 1;
            CMD_GET_STATUS:     reply_len = 2;
            CMD_SET_OUTPUTS, CMD_SET_PLL, CMD_SET_PASSTHROUGH, CMD_SET_PMT_VETO,
            CMD_RESET_PLL, CMD_SET_TEST_INPUTS: reply_len = 0;
            default:            reply_len = 1;
        endcase
    endfunction

endpackage

// File: rtl/serial_cmd_if.sv
// Byte-level UART link between the command engine and the rx/tx pair.
// rx_ready/rx_data: received byte strobe; tx_busy: transmitter busy;
// tx_start/tx_data: one-cycle transmit request with its byte.
interface serial_cmd_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
    modport slave  (output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
endinterface

// File: rtl/hist_serializer.sv
// Histogram snapshot and byte stream source.
// capture: latch hist/hist_extra and clear the checksum; send: fold the
// current byte into the checksum; idx: byte index, idx==NHBYTES selects
// the checksum; byte_c: selected byte (combinational).
module hist_serializer #(
    parameter int unsigned NBINS  = 32,
    parameter int unsigned NEXTRA = 2,
    parameter int unsigned BINW   = 32,
    parameter int unsigned IW     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic                   send,
    input  logic [IW-1:0]          idx,
    input  logic [NBINS*BINW-1:0]  hist,
    input  logic [NEXTRA*BINW-1:0] hist_extra,
    output logic [7:0]             byte_c
);
    localparam int unsigned NHBYTES = (NBINS + NEXTRA) * BINW / 8;
    localparam int unsigned BW      = (NHBYTES > 1) ? $clog2(NHBYTES) : 1;

    logic [NHBYTES-1:0][7:0] snap_q;
    logic [7:0]              csum_q;
    logic                    in_data_c;

    assign in_data_c = (idx < IW'(NHBYTES));

    // Extras sit above the bins so byte order falls out of the packing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
            csum_q <= 8'h00;
        end else if (capture) begin
            snap_q <= {hist_extra, hist};
            csum_q <= 8'h00;
        end else if (send && in_data_c) begin
            csum_q <= csum_q ^ byte_c;
        end
    end

    always_comb begin
        byte_c = csum_q;
        if (in_data_c) byte_c = snap_q[idx[BW-1:0]];
    end
endmodule

// File: rtl/serial_cmd_engine.sv
// Byte-serial command processor between the UART and the trigger core.
// clk/reset: clock and async active-high reset; uart: rx/tx byte link;
// configuration outputs (line drivers, passthrough, veto, test pulses,
// PLL shifts/source with update strobe); hist/hist_extra: counters
// streamed on request; reset_hist: clear strobe after snapshot;
// cmd_error: strobe on unknown opcode or argument timeout.
module serial_cmd_engine
    import serial_cmd_pkg::*;
#(
    parameter int unsigned NBINS       = 32,
    parameter int unsigned BINW        = 32,
    parameter int unsigned NEXTRA      = 2,
    parameter int unsigned NPLL        = 6,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  VERSION     = 8'd24
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_cmd_if.master           uart,
    output logic [7:0]             last_cmd,
    output logic                   disable_line_drivers,
    output logic                   enable_debug_outputs,
    output logic                   passthrough,
    output logic [2:0]             veto_pmt_last,
    output logic                   use_internal_test_pulse,
    output logic                   use_external_test_pulse,
    output logic                   update_pll,
    output logic                   pll_clk_src,
    output logic [8*NPLL-1:0]      pll_shifts,
    input  logic [NBINS*BINW-1:0]  hist,
    input  logic [NEXTRA*BINW-1:0] hist_extra,
    output logic                   reset_hist,
    output logic                   cmd_error
);
    localparam int unsigned NHBYTES = (NBINS + NEXTRA) * BINW / 8;
    localparam int unsigned KW      = $clog2(NHBYTES + 2);
    localparam int unsigned AW      = (NPLL + 1 > 1) ? $clog2(NPLL + 1) : 1;
    localparam int unsigned TW      = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARGS, S_EXEC, S_SNAP, S_TX_WAIT, S_TX_GAP, S_PLL_PULSE
    } state_t;

    state_t          state_q, state_d;
    cmd_t            cmd_c;
    logic [7:0]      args_q [NPLL+1];
    logic [AW-1:0]   arg_idx_q;
    logic [TW-1:0]   to_cnt_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   total_c;
    logic [7:0]      err_cnt;
    logic [1:0][7:0] reply_q;
    logic [7:0]      status_c;
    logic [7:0]      ser_byte_c;
    logic [7:0]      tx_byte_c;
    logic            timeout_c;
    logic            last_arg_c;
    logic            send_c;

    assign cmd_c      = cmd_t'(last_cmd);
    assign total_c    = KW'(reply_len(cmd_c, NBINS, NEXTRA, BINW));
    assign timeout_c  = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign last_arg_c = (arg_idx_q == AW'(arg_count(cmd_c, NPLL) - 1));
    assign send_c     = (state_q == S_TX_WAIT) && !uart.tx_busy;
    assign tx_byte_c  = (cmd_c == CMD_SEND_HISTOGRAM) ? ser_byte_c : reply_q[k_q[0]];

    always_comb begin
        status_c                      = 8'h00;
        status_c[ST_DRIVERS_EN]       = ~disable_line_drivers;
        status_c[ST_VETO_LSB +: 3]    = veto_pmt_last;
        status_c[ST_PASSTHROUGH]      = passthrough;
        status_c[ST_INT_PULSE]        = use_internal_test_pulse;
        status_c[ST_EXT_PULSE]        = use_external_test_pulse;
        status_c[ST_PLL_CLK_SRC]      = pll_clk_src;
    end

    hist_serializer #(.NBINS(NBINS), .NEXTRA(NEXTRA), .BINW(BINW), .IW(KW)) u_ser (
        .clk        (clk),
        .reset      (reset),
        .capture    (state_q == S_SNAP),
        .send       (send_c && (cmd_c == CMD_SEND_HISTOGRAM)),
        .idx        (k_q),
        .hist       (hist),
        .hist_extra (hist_extra),
        .byte_c     (ser_byte_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (uart.rx_ready)
                state_d = (arg_count(cmd_t'(uart.rx_data), NPLL) != 0) ? S_ARGS : S_EXEC;
            S_ARGS: begin
                if (uart.rx_ready) begin
                    if (last_arg_c) state_d = S_EXEC;
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                case (cmd_c)
                    CMD_SET_PLL, CMD_RESET_PLL: state_d = S_PLL_PULSE;
                    CMD_SEND_HISTOGRAM:         state_d = S_SNAP;
                    CMD_VERSION, CMD_GET_STATUS: state_d = S_TX_WAIT;
                    CMD_SET_OUTPUTS, CMD_SET_PASSTHROUGH,
                    CMD_SET_PMT_VETO, CMD_SET_TEST_INPUTS: state_d = S_IDLE;
                    default:                    state_d = S_TX_WAIT;
                endcase
            end
            S_SNAP:      state_d = S_TX_WAIT;
            S_TX_WAIT:   if (!uart.tx_busy) state_d = S_TX_GAP;
            S_TX_GAP:    state_d = (k_q < total_c - KW'(1)) ? S_TX_WAIT : S_IDLE;
            S_PLL_PULSE: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_cmd                <= 8'h00;
            disable_line_drivers    <= 1'b0;
            enable_debug_outputs    <= 1'b0;
            passthrough             <= 1'b0;
            veto_pmt_last           <= 3'b001;
            use_internal_test_pulse <= 1'b0;
            use_external_test_pulse <= 1'b0;
            update_pll              <= 1'b0;
            pll_clk_src             <= 1'b0;
            pll_shifts              <= '0;
            reset_hist              <= 1'b0;
            cmd_error               <= 1'b0;
            uart.tx_start           <= 1'b0;
            uart.tx_data            <= 8'h00;
            for (int i = 0; i <= NPLL; i++) args_q[i] <= 8'h00;
            arg_idx_q               <= '0;
            to_cnt_q                <= '0;
            k_q                     <= '0;
            err_cnt                 <= 8'h00;
            reply_q                 <= '0;
        end else begin
            uart.tx_start <= 1'b0;
            update_pll    <= 1'b0;
            reset_hist    <= 1'b0;
            cmd_error     <= 1'b0;
            case (state_q)
                S_IDLE: if (uart.rx_ready) begin
                    last_cmd  <= uart.rx_data;
                    arg_idx_q <= '0;
                    to_cnt_q  <= '0;
                    k_q       <= '0;
                end
                S_ARGS: begin
                    if (uart.rx_ready) begin
                        args_q[arg_idx_q] <= uart.rx_data;
                        arg_idx_q         <= arg_idx_q + AW'(1);
                        to_cnt_q          <= '0;
                    end else if (timeout_c) begin
                        cmd_error <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                S_EXEC: begin
                    case (cmd_c)
                        CMD_VERSION: reply_q[0] <= VERSION;
                        CMD_SET_OUTPUTS: begin
                            disable_line_drivers <= ~args_q[0][0];
                            enable_debug_outputs <= args_q[0][1];
                        end
                        CMD_SET_PLL: begin
                            for (int i = 0; i < NPLL; i++) pll_shifts[8*i +: 8] <= args_q[i];
                            pll_clk_src <= args_q[NPLL][0];
                            update_pll  <= 1'b1;
                        end
                        CMD_SET_PASSTHROUGH: passthrough <= |args_q[0];
                        CMD_SEND_HISTOGRAM: ;
                        CMD_SET_PMT_VETO: veto_pmt_last <= args_q[0][2:0];
                        CMD_RESET_PLL: begin
                            pll_shifts  <= '0;
                            pll_clk_src <= 1'b0;
                            update_pll  <= 1'b1;
                        end
                        CMD_SET_TEST_INPUTS: begin
                            use_internal_test_pulse <= args_q[0][0];
                            use_external_test_pulse <= args_q[0][1];
                        end
                        CMD_GET_STATUS: begin
                            reply_q[0] <= err_cnt;
                            reply_q[1] <= status_c;
                        end
                        default: begin
                            reply_q[0] <= NACK_BYTE;
                            cmd_error  <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    endcase
                end
                S_SNAP: reset_hist <= 1'b1;
                S_TX_WAIT: if (!uart.tx_busy) begin
                    uart.tx_start <= 1'b1;
                    uart.tx_data  <= tx_byte_c;
                end
                S_TX_GAP: if (k_q < total_c - KW'(1)) k_q <= k_q + KW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_cmd_engine.md
Name: serial_cmd_engine

Overview:
Parametrised byte-serial command processor between the UART rx/tx pair and the trigger/histogram core.
- Decodes one-byte opcodes plus argument bytes and drives the configuration outputs (line drivers, PLL phase shifts, veto, test pulses).
- Streams a snapshot of NBINS+NEXTRA histogram counters with a trailing XOR checksum.
- Adds a per-command argument timeout, NACK on unknown opcodes, a status readback command and a PLL clock-source argument.

Parameters:
NBINS, 32, number of histogram bins
BINW, 32, bits per bin; multiple of 8
NEXTRA, 2, extra counters appended after bins
NPLL, 6, number of PLL phase-shift bytes
TIMEOUT_CYC, 1000000, idle clk cycles allowed between argument bytes
VERSION, 8'd24, firmware version byte

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_ready  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle transmit strobe
tx_data  out  8  byte to transmit, valid with tx_start
last_cmd  out  8  most recent opcode byte received
disable_line_drivers  out  1  high disables outputs
enable_debug_outputs  out  1  debug output enable
passthrough  out  1  passthrough mode
veto_pmt_last  out  3  PMT veto mask
use_internal_test_pulse  out  1  internal test pulse select
use_external_test_pulse  out  1  external test pulse select
update_pll  out  1  one-cycle PLL reconfigure strobe
pll_clk_src  out  1  PLL reference select
pll_shifts  out  8*NPLL  phase shifts; byte i at [8i+7:8i]
hist  in  NBINS*BINW  bin i at [BINW*i+BINW-1:BINW*i]
hist_extra  in  NEXTRA*BINW  same packing
reset_hist  out  1  one-cycle histogram clear
cmd_error  out  1  one-cycle strobe on unknown opcode or timeout

Behaviour:
- Reset values: all outputs 0 except veto_pmt_last=3'b001. Internal err_cnt=0. State IDLE.
- Opcodes, with argument count / reply bytes:
  - 0 VERSION: 0 args / 1 byte, VERSION.
  - 1 SET_OUTPUTS: 1 arg / none. disable_line_drivers=!a0[0], enable_debug_outputs=a0[1].
  - 2 SET_PLL: NPLL+1 args / none. pll_shifts=a0..a(NPLL-1); pll_clk_src=a(NPLL)[0]; then update_pll.
  - 3 SET_PASSTHROUGH: 1 arg / none. passthrough=(a0!=0).
  - 4 SEND_HISTOGRAM: 0 args / (NBINS+NEXTRA)*BINW/8+1 bytes.
  - 5 SET_PMT_VETO: 1 arg / none. veto_pmt_last=a0[2:0].
  - 6 RESET_PLL: 0 args / none. pll_shifts=0, pll_clk_src=0, then update_pll.
  - 7 SET_TEST_INPUTS: 1 arg / none. internal=a0[0], external=a0[1].
  - 8 GET_STATUS: 0 args / 2 bytes. Byte 0 = err_cnt. Byte 1 = {pll_clk_src, use_external_test_pulse, use_internal_test_pulse, passthrough, veto_pmt_last, !disable_line_drivers} (MSB first).
  - >=9: 0 args / 1 byte, NACK 8'hEE; cmd_error pulses; err_cnt increments.
- FSM states: IDLE, ARGS, EXEC, SNAP, TX_WAIT, TX_GAP, PLL_PULSE.
- IDLE:
  - On rx_ready, latch opcode into last_cmd.
  - If the opcode has arguments go to ARGS with arg_idx=0; otherwise go to EXEC.
- ARGS:
  - Each rx_ready stores a byte at arg_idx, increments arg_idx and clears the timeout counter.
  - When arg_idx reaches the opcode's argument count, go to EXEC on the next cycle.
  - Each cycle without rx_ready increments the timeout counter. When it reaches TIMEOUT_CYC-1: pulse cmd_error, increment err_cnt, discard arguments, go to IDLE. No reply byte and no output change.
- EXEC, single cycle:
  - Set commands update their outputs and return to IDLE.
  - PLL commands go to PLL_PULSE.
  - SEND_HISTOGRAM goes to SNAP.
  - Reply commands load the reply buffer and go to TX_WAIT.
- SNAP: copy hist and hist_extra into the snapshot register. reset_hist is high exactly on the following cycle. Go to TX_WAIT.
- PLL_PULSE: update_pll=1 for exactly one cycle, then IDLE. New pll_shifts/pll_clk_src are already stable when update_pll is high.
- Transmit handshake:
  - TX_WAIT: when !tx_busy, drive tx_data=byte[k] and tx_start=1 for one cycle, then go to TX_GAP.
  - TX_GAP: one dead cycle. The UART asserts tx_busy within one cycle of tx_start. Then, if k < total-1, increment k and return to TX_WAIT; else go to IDLE.
- Histogram byte order: bins 0..NBINS-1, then extras 0..NEXTRA-1, each little-endian. The last byte is the XOR of all preceding bytes, accumulated as bytes are sent.
- Overflow rules:
  - err_cnt saturates at 8'hFF.
  - The byte counter is wide enough for (NBINS+NEXTRA)*BINW/8+1.
- Ignored input: rx_ready outside IDLE/ARGS is dropped.
- Reset mid-transmit: the transfer is abandoned immediately; tx_start is forced 0.

Decomposition:
- Package serial_cmd_pkg holds:
  - opcode enum cmd_t
  - argument-count and reply-length functions of (cmd_t, NPLL, NBINS, NEXTRA, BINW)
  - NACK_BYTE=8'hEE
  - status bit positions
- Sub-module hist_serializer owns the snapshot register, the byte-select mux (index -> byte) and the XOR checksum. It is parametrised by NBINS, NEXTRA and BINW.

Test Plan:
- Version: send 0x00 with tx_busy held 1 for 5 cycles -> no tx_start until tx_busy falls, then exactly one tx_start with tx_data=0x18.
- PLL set: send 0x02,1,2,3,4,5,6,0x01 -> pll_shifts=0x060504030201, pll_clk_src=1, then update_pll high exactly one cycle. Then send 0x06 -> all 0, update_pll pulse.
- Histogram: NBINS=4, BINW=16, NEXTRA=1, hist bin i=0x0100+i, extra=0xABCD, send 0x04 -> bytes 00,01,01,01,02,01,03,01,CD,AB, checksum 0x66. reset_hist is one cycle after the snapshot. hist changes during transmission do not alter the bytes sent.
- Timeout: TIMEOUT_CYC=100, send 0x01 then silence -> cmd_error at cycle 100, outputs unchanged. 0x08 then returns 0x01,0x03.
- Unknown opcode: send 0x2A -> reply 0xEE, cmd_error pulse, last_cmd=0x2A.
- Reset: assert reset during the 3rd histogram byte -> outputs at reset values, FSM in IDLE. Next VERSION command works normally.
